// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit: FSM state, next-PC
// source encoding, default step/reset vector and the alignment check.
package pc_pkg;

    localparam int unsigned PC_STEP_DEFAULT      = 4;
    localparam logic [63:0] PC_RESET_VEC_DEFAULT = 64'h0;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_HALT,
        ST_ERR
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_ADV,
        SRC_HALT,
        SRC_REDIR,
        SRC_TRAP,
        SRC_MRET
    } pc_src_e;

    // step is a power of two, so the low log2(step) bits must be zero
    function automatic logic pc_is_aligned(input logic [63:0] addr, input int unsigned step);
        logic [63:0] mask;
        mask = 64'(step) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch request channel between the PC unit (master) and instruction memory (slave).
interface pc_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_pc;

    modport master (output fetch_valid, output fetch_pc, input fetch_ready);
    modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_target_arb.sv
// Combinational priority select of the next fetch address and its source.
// Trap/mret sources exist only when PC_TRAP_EN is defined.
module pc_target_arb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned STEP = PC_STEP_DEFAULT
) (
    input  logic            active_i,
    input  logic            run_i,
    input  logic            handshake_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_en_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    input  logic            halt_req_i,
`ifdef PC_TRAP_EN
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic            mret_req_i,
    input  logic [XLEN-1:0] epc_i,
`endif
    output pc_src_e         src_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] pc_inc;
    assign pc_inc = pc_i + XLEN'(STEP);

    always_comb begin
        src_o      = SRC_HOLD;
        target_o   = pc_i;
        misalign_o = 1'b0;
        if (active_i) begin
`ifdef PC_TRAP_EN
            if (trap_req_i) begin
                src_o      = SRC_TRAP;
                misalign_o = !pc_is_aligned(64'(trap_target_i), STEP) ||
                             !pc_is_aligned(64'(trap_epc_i), STEP);
                // on a bad trap, expose whichever address was misaligned
                target_o   = (pc_is_aligned(64'(trap_target_i), STEP) &&
                              !pc_is_aligned(64'(trap_epc_i), STEP)) ? trap_epc_i : trap_target_i;
            end else if (mret_req_i) begin
                src_o    = SRC_MRET;
                target_o = epc_i;
            end else
`endif
            if (redirect_en_i) begin
                src_o      = SRC_REDIR;
                target_o   = redirect_addr_i;
                misalign_o = !pc_is_aligned(64'(redirect_addr_i), STEP);
            end else if (run_i && halt_req_i) begin
                src_o    = SRC_HALT;
                target_o = handshake_i ? pc_inc : pc_i;
            end else if (run_i && handshake_i) begin
                src_o    = SRC_ADV;
                target_o = pc_inc;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: FSM, PC, fetch counter and (with PC_TRAP_EN)
// the trap return address register.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC_DEFAULT),
    parameter int unsigned     STEP      = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    pc_unit_if.master       fetch_if,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            halt_req,
`ifdef PC_TRAP_EN
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_target,
    input  logic [XLEN-1:0] trap_epc,
    input  logic            mret_req,
    output logic [XLEN-1:0] epc,
`endif
    output logic            halted,
    output logic            misalign_err,
    output logic [63:0]     fetch_count
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [63:0]     count_q, count_d;
    logic            handshake;
    pc_src_e         arb_src;
    logic [XLEN-1:0] arb_target;
    logic            arb_misalign;
`ifdef PC_TRAP_EN
    logic [XLEN-1:0] epc_q, epc_d;
`endif

    assign fetch_if.fetch_valid = (state_q == ST_RUN);
    assign fetch_if.fetch_pc    = pc_q;
    assign handshake            = fetch_if.fetch_valid && fetch_if.fetch_ready;
    assign halted               = (state_q == ST_HALT) || (state_q == ST_ERR);
    assign misalign_err         = (state_q == ST_ERR);
    assign fetch_count          = count_q;

    pc_target_arb #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_arb (
        .active_i        ((state_q == ST_RUN) || (state_q == ST_HALT)),
        .run_i           (state_q == ST_RUN),
        .handshake_i     (handshake),
        .pc_i            (pc_q),
        .redirect_en_i   (redirect_en),
        .redirect_addr_i (redirect_addr),
        .halt_req_i      (halt_req),
`ifdef PC_TRAP_EN
        .trap_req_i      (trap_req),
        .trap_target_i   (trap_target),
        .trap_epc_i      (trap_epc),
        .mret_req_i      (mret_req),
        .epc_i           (epc_q),
`endif
        .src_o           (arb_src),
        .target_o        (arb_target),
        .misalign_o      (arb_misalign)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        // an accepted request always counts, whatever else happens this cycle
        count_d = count_q + 64'(handshake);
`ifdef PC_TRAP_EN
        epc_d   = epc_q;
`endif
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN, ST_HALT: begin
                pc_d = arb_target;
                if (arb_misalign) begin
                    state_d = ST_ERR;
                end else begin
                    case (arb_src)
                        SRC_TRAP, SRC_MRET, SRC_REDIR: state_d = ST_RUN;
                        SRC_HALT:                      state_d = ST_HALT;
                        default:                       state_d = state_q;
                    endcase
`ifdef PC_TRAP_EN
                    if (arb_src == SRC_TRAP) epc_d = trap_epc;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_VEC;
            count_q <= 64'd0;
`ifdef PC_TRAP_EN
            epc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
`ifdef PC_TRAP_EN
            epc_q   <= epc_d;
`endif
        end
    end

`ifdef PC_TRAP_EN
    assign epc = epc_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_pc_unit;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] STEP = 64'd4;
    localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ren;
    logic [63:0] raddr;
    logic        hreq;
    logic        treq;
    logic [63:0] ttgt;
    logic [63:0] tepc;
    logic        mreq;
    logic        halted;
    logic        misalign_err;
    logic [63:0] fetch_count;
    logic [63:0] epc_out;

    int          m_mode;
    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    logic [63:0] m_epc;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    pc_unit_if #(.XLEN(XLEN)) fif ();
    assign fif.fetch_ready = rdy;

    pc_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (64'h0),
        .STEP      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_if      (fif),
        .redirect_en   (ren),
        .redirect_addr (raddr),
        .halt_req      (hreq),
`ifdef PC_TRAP_EN
        .trap_req      (treq),
        .trap_target   (ttgt),
        .trap_epc      (tepc),
        .mret_req      (mreq),
        .epc           (epc_out),
`endif
        .halted        (halted),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

`ifndef PC_TRAP_EN
    assign epc_out = 64'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic aligned(input logic [63:0] a);
        return (a % STEP) == 64'd0;
    endfunction

    // Advances the model across one clock edge using the current inputs.
    task automatic model_edge();
        logic accepted;
        accepted = (m_mode == M_RUN) && rdy;
        if (rst) begin
            m_mode = M_RESET;
            m_pc   = 64'h0;
            m_cnt  = 64'd0;
            m_epc  = 64'd0;
            return;
        end
        if (accepted) m_cnt = m_cnt + 64'd1;
        if (m_mode == M_RESET) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN || m_mode == M_HALT) begin
`ifdef PC_TRAP_EN
            if (treq) begin
                if (!aligned(ttgt)) begin
                    m_pc = ttgt; m_mode = M_ERR;
                end else if (!aligned(tepc)) begin
                    m_pc = tepc; m_mode = M_ERR;
                end else begin
                    m_pc = ttgt; m_epc = tepc; m_mode = M_RUN;
                end
                return;
            end
            if (mreq) begin
                m_pc = m_epc; m_mode = M_RUN;
                return;
            end
`endif
            if (ren) begin
                m_pc   = raddr;
                m_mode = aligned(raddr) ? M_RUN : M_ERR;
            end else if (m_mode == M_RUN) begin
                if (accepted) m_pc = m_pc + STEP;
                if (hreq) m_mode = M_HALT;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d rst=%b rdy=%b ren=%b raddr=%h halt=%b trap=%b mret=%b -> valid=%b pc=%h cnt=%0d halted=%b err=%b",
                 cyc, rst, rdy, ren, raddr, hreq, treq, mreq, fif.fetch_valid, fif.fetch_pc,
                 fetch_count, halted, misalign_err);
        check("fetch_valid",  64'(fif.fetch_valid), 64'(m_mode == M_RUN));
        check("fetch_pc",     fif.fetch_pc, m_pc);
        check("fetch_count",  fetch_count, m_cnt);
        check("halted",       64'(halted), 64'(m_mode == M_HALT || m_mode == M_ERR));
        check("misalign_err", 64'(misalign_err), 64'(m_mode == M_ERR));
`ifdef PC_TRAP_EN
        check("epc",          epc_out, m_epc);
`endif
        rst = 1'b0; ren = 1'b0; hreq = 1'b0; treq = 1'b0; mreq = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] a, input logic r);
        ren = 1'b1; raddr = a; rdy = r;
        cycle();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; ren = 1'b0; raddr = 64'h0; hreq = 1'b0;
        treq = 1'b0; ttgt = 64'h0; tepc = 64'h0; mreq = 1'b0;
        m_mode = M_RESET; m_pc = 64'h0; m_cnt = 64'd0; m_epc = 64'd0;

        // reset held, then released with memory always ready
        rst = 1'b1; cycle();
        rst = 1'b1; rdy = 1'b1; cycle();
        for (int i = 0; i < 4; i++) begin rdy = 1'b1; cycle(); end
        // memory stalls: address and count must hold
        for (int i = 0; i < 4; i++) begin rdy = 1'b0; cycle(); end
        // redirect coinciding with an accepted fetch
        redirect(64'h1000, 1'b1);
        rdy = 1'b1; cycle();
        // redirect while stalled cancels the request
        redirect(64'h1800, 1'b0);
        // halt with a handshake in the same cycle, idle, then resume
        hreq = 1'b1; rdy = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin hreq = (i == 2); rdy = 1'b1; cycle(); end
        redirect(64'h2000, 1'b0);
        rdy = 1'b1; cycle();
        // address wrap at the top of the space
        redirect(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        rdy = 1'b1; cycle();
        rdy = 1'b1; cycle();
        // misaligned redirect is sticky until reset
        redirect(64'h1002, 1'b1);
        redirect(64'h3000, 1'b1);
        hreq = 1'b1; cycle();
        rdy = 1'b1; cycle();
        rst = 1'b1; ren = 1'b1; raddr = 64'h4000; cycle();
        rdy = 1'b1; cycle();
        // halt, then a misaligned redirect from HALT
        hreq = 1'b1; rdy = 1'b0; cycle();
        redirect(64'h5001, 1'b1);
        rst = 1'b1; cycle();
        rdy = 1'b1; cycle();
`ifdef PC_TRAP_EN
        treq = 1'b1; ttgt = 64'h100; tepc = 64'h2004; rdy = 1'b1; cycle();
        rdy = 1'b1; cycle();
        mreq = 1'b1; rdy = 1'b0; cycle();
        rdy = 1'b1; cycle();
        treq = 1'b1; mreq = 1'b1; ttgt = 64'h200; tepc = 64'h3008; cycle();
        hreq = 1'b1; cycle();
        treq = 1'b1; ttgt = 64'h300; tepc = 64'h400; cycle();
        hreq = 1'b1; cycle();
        mreq = 1'b1; cycle();
        treq = 1'b1; ttgt = 64'h500; tepc = 64'h602; cycle();
        rst = 1'b1; cycle();
        rdy = 1'b1; cycle();
`endif

        // random phase
        for (int i = 0; i < 300; i++) begin
            rdy  = ($urandom_range(0, 3) != 0);
            hreq = ($urandom_range(0, 15) == 0);
            ren  = ($urandom_range(0, 7) == 0);
            raddr = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 19) == 0) raddr = raddr | 64'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) raddr = 64'hFFFF_FFFF_FFFF_FFF0;
`ifdef PC_TRAP_EN
            treq = ($urandom_range(0, 15) == 0);
            mreq = ($urandom_range(0, 15) == 0);
            ttgt = {$urandom, $urandom} & ~64'h3;
            tepc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 19) == 0) tepc = tepc | 64'h1;
`endif
            rst = (m_mode == M_ERR) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
